// File: rtl/qar_bus_pkg.sv
// Shared QAR memory-bus definitions: bus width defaults, mailbox address,
// responder FSM state type and the out-of-range read pattern.
package qar_bus_pkg;

  localparam int          QAR_DATA_W  = 32;
  localparam int          QAR_ADDR_W  = 32;
  localparam logic [31:0] QAR_TOHOST  = 32'h0000_FFF0;
  localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } qar_mem_state_t;

endpackage

// File: rtl/qar_bus_mem_if.sv
// QAR memory bus. The master raises mem_req and holds addr/wdata/we/be stable
// until the slave returns a single-cycle mem_ready; mem_rdata is valid only with it.
interface qar_bus_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();

  logic                  mem_req;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_ready;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_addr, mem_wdata, mem_we, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, mem_wdata, mem_we, mem_be,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/qar_sram_be.sv
// Synchronous single-read/single-write RAM with per-byte write enables.
// Read data is registered; contents are never cleared.
module qar_sram_be #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  localparam int IDX_W      = $clog2(DEPTH_WORDS),
  localparam int BYTES      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BYTES-1:0]  be,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/qar_bus_mem.sv
// QAR bus memory responder with programmable wait states and a tohost mailbox.
// Optional out-of-range detection is enabled by defining QAR_MEM_ERR_EN.
module qar_bus_mem
  import qar_bus_pkg::*;
#(
  parameter int                DATA_W      = QAR_DATA_W,
  parameter int                ADDR_W      = QAR_ADDR_W,
  parameter int                DEPTH_WORDS = 1024,
  parameter int                LATENCY     = 1,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(QAR_TOHOST)
) (
  input  logic               clk,
  input  logic               rst,
  qar_bus_mem_if.slave       bus,
  output logic               done,
  output logic [DATA_W-1:0]  done_code,
  output logic               mem_err,
  output qar_mem_state_t     dbg_state
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  qar_mem_state_t      state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [BYTES-1:0]    be_q, be_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   code_q, code_d;
  logic                err_q, err_d;

  logic                ram_we;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   ram_rdata;
  logic [DATA_W-1:0]   rd_value;
  logic                is_tohost;
  logic                oor;

  assign idx       = addr_q[OFF_W +: IDX_W];
  assign is_tohost = (addr_q == TOHOST_ADDR);

`ifdef QAR_MEM_ERR_EN
  logic [DATA_W-1:0] err_word;
  always_comb begin
    err_word = '0;
    for (int i = 0; i < DATA_W; i++) err_word[i] = ERR_PATTERN[i % 32];
  end
  assign oor      = !is_tohost && ({1'b0, addr_q} >= (ADDR_W+1)'(DEPTH_WORDS * BYTES));
  assign rd_value = is_tohost ? '0 : (oor ? err_word : ram_rdata);
`else
  assign oor      = 1'b0;
  assign rd_value = is_tohost ? '0 : ram_rdata;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    be_d    = be_q;
    ready_d = 1'b0;
    rdata_d = rdata_q;
    done_d  = done_q;
    code_d  = code_q;
    err_d   = err_q;
    ram_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          addr_d  = bus.mem_addr;
          wdata_d = bus.mem_wdata;
          we_d    = bus.mem_we;
          be_d    = bus.mem_be;
          // One count beyond LATENCY gives the registered RAM read its cycle.
          cnt_d   = 5'(LATENCY) + 5'd1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 5'd0) begin
          state_d = RESP;
          ready_d = 1'b1;
          if (!we_q) rdata_d = rd_value;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (oor) err_d = 1'b1;
        if (we_q) begin
          if (is_tohost) begin
            done_d = 1'b1;
            if (!done_q) code_d = wdata_q;
          end else if (!oor) begin
            ram_we = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      code_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      be_q    <= be_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      code_q  <= code_d;
      err_q   <= err_d;
    end
  end

  // Reset on the commit edge must also cancel the RAM write.
  qar_sram_be #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we & ~rst),
    .be    (be_q),
    .waddr (idx),
    .wdata (wdata_q),
    .raddr (idx),
    .rdata (ram_rdata)
  );

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign done          = done_q;
  assign done_code     = code_q;
  assign mem_err       = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_qar_bus_mem.sv
// Directed bench for qar_bus_mem: one instance with LATENCY=0, one with LATENCY=3.
// Expectations follow QAR_MEM_ERR_EN when it is defined for the build.
module tb_qar_bus_mem;
  import qar_bus_pkg::*;

  logic clk;
  logic rst0, rst3;
  int   checks;
  int   errors;

  qar_bus_mem_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();
  qar_bus_mem_if #(.DATA_W(32), .ADDR_W(32)) bus3 ();

  logic           done0, done3, err0, err3;
  logic [31:0]    code0, code3;
  qar_mem_state_t dbg0, dbg3;

  qar_bus_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst0), .bus(bus0.slave),
    .done(done0), .done_code(code0), .mem_err(err0), .dbg_state(dbg0)
  );

  qar_bus_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(1024), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst3), .bus(bus3.slave),
    .done(done3), .done_code(code3), .mem_err(err3), .dbg_state(dbg3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? bus0.mem_ready : bus3.mem_ready;
  endfunction

  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? bus0.mem_rdata : bus3.mem_rdata;
  endfunction

  // driver tasks
  task automatic drive(input int sel, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    if (sel == 0) begin
      bus0.mem_req = req; bus0.mem_we = we; bus0.mem_addr = addr;
      bus0.mem_wdata = wdata; bus0.mem_be = be;
    end else begin
      bus3.mem_req = req; bus3.mem_we = we; bus3.mem_addr = addr;
      bus3.mem_wdata = wdata; bus3.mem_be = be;
    end
  endtask

  task automatic txn(input int sel, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int lat,
                     input string tag, output logic [31:0] rd);
    int   k;
    logic seen;
    @(negedge clk);
    drive(sel, 1'b1, we, addr, wdata, be);
    @(posedge clk);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(posedge clk);
      #1;
      k++;
      seen = get_ready(sel);
    end
    chk({tag, "_lat"}, 32'(k), 32'(2 + lat));
    rd = get_rdata(sel);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {31'd0, get_ready(sel)}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    checks = 0;
    errors = 0;
    rst0 = 1'b1;
    rst3 = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(3, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, bus0.mem_ready}, 32'd0);
    chk("rst_rdata", bus0.mem_rdata, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_code", code0, 32'd0);
    chk("rst_err", {31'd0, err0}, 32'd0);
    chk("rst_state", 32'(dbg0), 32'(IDLE));
    @(negedge clk);
    rst0 = 1'b0;
    rst3 = 1'b0;

    // 1: LATENCY=0 write then read
    txn(0, 1'b1, 32'h10, 32'h1122_3344, 4'hF, 0, "t1_wr", rd);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, "t1_rd", rd);
    chk("t1_rdata", rd, 32'h1122_3344);

    // 2: LATENCY=3
    txn(3, 1'b1, 32'h10, 32'h1122_3344, 4'hF, 3, "t2_wr", rd);
    txn(3, 1'b0, 32'h10, 32'h0, 4'h0, 3, "t2_rd", rd);
    chk("t2_rdata", rd, 32'h1122_3344);

    // 3: byte enables
    txn(0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, 0, "t3_wr", rd);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, "t3_rd", rd);
    chk("t3_rdata", rd, 32'h11BB_33DD);

    // 4: tohost mailbox; 0xFFF0 aliases RAM byte 0xFF0 in a 1024-word RAM
    txn(0, 1'b1, 32'hFF0, 32'h1234_5678, 4'hF, 0, "t4_pre", rd);
    chk("t4_done_before", {31'd0, done0}, 32'd0);
    txn(0, 1'b1, 32'hFFF0, 32'h0000_0001, 4'hF, 0, "t4_th1", rd);
    chk("t4_done", {31'd0, done0}, 32'd1);
    chk("t4_code1", code0, 32'd1);
    txn(0, 1'b1, 32'hFFF0, 32'h0000_0007, 4'hF, 0, "t4_th7", rd);
    chk("t4_code_kept", code0, 32'd1);
    txn(0, 1'b0, 32'hFF0, 32'h0, 4'h0, 0, "t4_ram", rd);
    chk("t4_ram_kept", rd, 32'h1234_5678);
    txn(0, 1'b0, 32'hFFF0, 32'h0, 4'h0, 0, "t4_thrd", rd);
    chk("t4_tohost_rd", rd, 32'h0);

    // 5: reset during WAIT cancels a write
    txn(3, 1'b1, 32'h20, 32'h5555_AAAA, 4'hF, 3, "t5_pre", rd);
    @(negedge clk);
    drive(3, 1'b1, 1'b1, 32'h20, 32'h9999_0000, 4'hF);
    @(posedge clk);
    #1;
    chk("t5_state_wait", 32'(dbg3), 32'(WAIT));
    @(posedge clk);
    @(negedge clk);
    rst3 = 1'b1;
    drive(3, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk);
    #1;
    chk("t5_rst_ready", {31'd0, bus3.mem_ready}, 32'd0);
    chk("t5_rst_state", 32'(dbg3), 32'(IDLE));
    @(negedge clk);
    rst3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("t5_no_ready", {31'd0, bus3.mem_ready}, 32'd0);
    end
    txn(3, 1'b0, 32'h20, 32'h0, 4'h0, 3, "t5_rd", rd);
    chk("t5_old_word", rd, 32'h5555_AAAA);

    // 6: address beyond the RAM
    txn(0, 1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, 0, "t6_pre", rd);
    txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, "t6_rd", rd);
`ifdef QAR_MEM_ERR_EN
    chk("t6_rdata", rd, 32'hDEAD_BEEF);
    chk("t6_err", {31'd0, err0}, 32'd1);
`else
    chk("t6_rdata", rd, 32'h0BAD_F00D);
    chk("t6_err", {31'd0, err0}, 32'd0);
`endif
    chk("t6_err3", {31'd0, err3}, 32'd0);
    chk("t6_done3", {31'd0, done3}, 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
